// File: rtl/sm_mul_pkg.sv
// Shared arithmetic definitions for the sign-magnitude Q7.8 multiplier and divider.
// Provides format widths, saturation constants and the common FSM state encoding.
package sm_mul_pkg;

   localparam int WIDTH    = 16;
   localparam int FRAC     = 8;
   localparam int SIGN_BIT = WIDTH - 1;
   localparam int MAG_W    = WIDTH - 1;
   localparam int PROD_W   = 2 * MAG_W;
   localparam int CNT_W    = $clog2(MAG_W + 1);

   localparam logic [MAG_W-1:0] MAG_MAX = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_e;

endpackage

// File: rtl/sm_sat.sv
// Combinational normalize/round/saturate stage: raw magnitude product + sign -> Q7.8 result.
// SM_MUL_ROUND_EN selects round-half-up; otherwise the magnitude is truncated.
module sm_sat
   import sm_mul_pkg::*;
(
   input  logic [PROD_W-1:0] prod_raw_i,
   input  logic              sign_i,
   output logic [WIDTH-1:0]  product_o,
   output logic              ovf_o
);

   logic [PROD_W:0]      p_adj;
   logic [PROD_W-FRAC:0] mag_wide;
   logic [MAG_W-1:0]     mag;

`ifdef SM_MUL_ROUND_EN
   localparam logic [PROD_W:0] RND_HALF = (PROD_W + 1)'(2 ** (FRAC - 1));
   assign p_adj = {1'b0, prod_raw_i} + RND_HALF;
`else
   assign p_adj = {1'b0, prod_raw_i};
`endif

   assign mag_wide = p_adj[PROD_W:FRAC];

   // Any bit above the 15-bit magnitude field means the value exceeds MAG_MAX.
   assign ovf_o = |mag_wide[PROD_W-FRAC:MAG_W];
   assign mag   = ovf_o ? MAG_MAX : mag_wide[MAG_W-1:0];

   assign product_o = {sign_i & (mag != '0), mag};

endmodule

// File: rtl/sm_mul.sv
// Sequential sign-magnitude Q7.8 multiplier: radix-2 shift-add over 15 cycles, saturated result.
// Optional build macro SM_MUL_ROUND_EN enables round-half-up in the output stage.
module sm_mul
   import sm_mul_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic             ovf
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PROD_W-1:0]  acc_q, acc_d;
   logic [MAG_W-1:0]   mcand_q, mcand_d;
   logic [MAG_W-1:0]   mplr_q, mplr_d;
   logic               sign_q, sign_d;
   logic [WIDTH-1:0]   product_q, product_d;
   logic               ovf_q, ovf_d;
   logic               done_q, done_d;
   logic [MAG_W:0]     add_sum;
   logic [WIDTH-1:0]   sat_product;
   logic               sat_ovf;

   sm_sat u_sat (
      .prod_raw_i (acc_q),
      .sign_i     (sign_q),
      .product_o  (sat_product),
      .ovf_o      (sat_ovf)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (cnt_q == CNT_W'(1)) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state_q != IDLE);
      done    = done_q;
      product = product_q;
      ovf     = ovf_q;
   end

   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      sign_d    = sign_q;
      product_d = product_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      add_sum   = {1'b0, acc_q[PROD_W-1:MAG_W]} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
      unique case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d = multiplicand[MAG_W-1:0];
               mplr_d  = multiplier[MAG_W-1:0];
               sign_d  = multiplicand[SIGN_BIT] ^ multiplier[SIGN_BIT];
               acc_d   = '0;
               cnt_d   = CNT_W'(MAG_W);
            end
         end
         RUN: begin
            // Carry of the upper-half add enters at the top as the pair shifts right.
            acc_d  = {add_sum, acc_q[MAG_W-1:1]};
            mplr_d = mplr_q >> 1;
            cnt_d  = cnt_q - CNT_W'(1);
         end
         FIN: begin
            product_d = sat_product;
            ovf_d     = sat_ovf;
            done_d    = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplr_q    <= '0;
         sign_q    <= 1'b0;
         product_q <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplr_q    <= mplr_d;
         sign_q    <= sign_d;
         product_q <= product_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_sm_mul.sv
// Self-checking bench for sm_mul: directed Q7.8 vectors, randomized operands against an
// arithmetic reference model, ignored start, back-to-back operation and reset abort.
module tb_sm_mul;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] multiplicand;
   logic [15:0] multiplier;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic        ovf;

   int checks = 0;
   int errors = 0;

`ifdef SM_MUL_ROUND_EN
   localparam logic [15:0] EXP_TINY_POS = 16'h0001;
   localparam logic [15:0] EXP_TINY_NEG = 16'h8001;
`else
   localparam logic [15:0] EXP_TINY_POS = 16'h0000;
   localparam logic [15:0] EXP_TINY_NEG = 16'h0000;
`endif

   sm_mul dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product),
      .ovf          (ovf)
   );

   always #5 clk = ~clk;

   // Reference: integer product of magnitudes, optional +0.5 LSB, divide by 2^8, clamp.
   function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] p, output logic o);
      logic [63:0] raw;
      logic [63:0] q;
      logic        s;
      raw = 64'(a[14:0]) * 64'(b[14:0]);
`ifdef SM_MUL_ROUND_EN
      raw = raw + 64'd128;
`endif
      q = raw / 64'd256;
      o = (q > 64'd32767);
      if (o) q = 64'd32767;
      s = (q != 64'd0) && (a[15] ^ b[15]);
      p = {s, q[14:0]};
   endfunction

   // Issues one operation starting now; returns result at the done cycle (or after a timeout).
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int pulse_at,
                         output logic [15:0] p, output logic o,
                         output int lat, output int busy_cnt);
      start = 1'b1;
      multiplicand = a;
      multiplier = b;
      @(posedge clk); #1;
      start = 1'b0;
      multiplicand = 16'($urandom);
      multiplier = 16'($urandom);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL done_width: done=%b after accept edge, expected 0", done);
      end
      lat = 0;
      busy_cnt = (busy === 1'b1) ? 1 : 0;
      while (lat < 40) begin
         if (lat == pulse_at) begin
            start = 1'b1;
            multiplicand = 16'h7F00;
            multiplier = 16'h7F00;
         end
         @(posedge clk); #1;
         lat++;
         start = 1'b0;
         if (done === 1'b1) break;
         if (busy === 1'b1) busy_cnt++;
      end
      p = product;
      o = ovf;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      multiplicand = 16'h0000;
      multiplier = 16'h0000;
      #2;
      checks++;
      if ({busy, done, ovf, product} !== 19'd0) begin
         errors++;
         $display("FAIL reset_values: busy=%b done=%b ovf=%b product=%h, expected all 0",
                  busy, done, ovf, product);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({busy, done, ovf, product} !== 19'd0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b done=%b ovf=%b product=%h, expected all 0",
                  busy, done, ovf, product);
      end
   endtask

   task automatic test_vectors();
      logic [15:0] va [8] = '{16'h0180, 16'h8180, 16'h8180, 16'h7F00,
                              16'hFF00, 16'h0001, 16'h8001, 16'h8000};
      logic [15:0] vb [8] = '{16'h0200, 16'h0200, 16'h8200, 16'h0200,
                              16'h0200, 16'h0080, 16'h0080, 16'h1234};
      logic [15:0] vp [8] = '{16'h0300, 16'h8300, 16'h0300, 16'h7FFF,
                              16'hFFFF, EXP_TINY_POS, EXP_TINY_NEG, 16'h0000};
      logic        vo [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [15:0] p;
      logic        o;
      int          lat, bc;
      for (int i = 0; i < 8; i++) begin
         run_op(va[i], vb[i], -1, p, o, lat, bc);
         checks++;
         if (p !== vp[i] || o !== vo[i]) begin
            errors++;
            $display("FAIL vector_%0d %h*%h: product=%h ovf=%b, expected product=%h ovf=%b",
                     i, va[i], vb[i], p, o, vp[i], vo[i]);
         end
         checks++;
         if (lat != 16 || bc != 16) begin
            errors++;
            $display("FAIL vector_timing_%0d: latency=%0d busy_cycles=%0d, expected 16/16",
                     i, lat, bc);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] a, b, p, ep;
      logic        o, eo;
      int          lat, bc;
      for (int i = 0; i < 24; i++) begin
         a = {1'($urandom), 15'($urandom) >> $urandom_range(0, 8)};
         b = {1'($urandom), 15'($urandom) >> $urandom_range(0, 8)};
         model(a, b, ep, eo);
         run_op(a, b, -1, p, o, lat, bc);
         checks++;
         if (p !== ep || o !== eo || lat != 16) begin
            errors++;
            $display("FAIL random_%0d %h*%h: product=%h ovf=%b lat=%0d, expected %h ovf=%b lat=16",
                     i, a, b, p, o, lat, ep, eo);
         end
      end
   endtask

   task automatic test_start_ignored();
      logic [15:0] p;
      logic        o;
      int          lat, bc;
      run_op(16'h0240, 16'h8300, 5, p, o, lat, bc);
      checks++;
      if (p !== 16'h86C0 || o !== 1'b0 || lat != 16) begin
         errors++;
         $display("FAIL start_ignored: product=%h ovf=%b lat=%0d, expected 86c0 ovf=0 lat=16",
                  p, o, lat);
      end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL start_not_queued: busy=%b after done, expected 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] p, ep;
      logic        o, eo;
      int          lat, bc;
      run_op(16'h0300, 16'h0280, -1, p, o, lat, bc);
      model(16'h0300, 16'h0280, ep, eo);
      checks++;
      if (p !== ep || o !== eo) begin
         errors++;
         $display("FAIL b2b_first: product=%h ovf=%b, expected %h ovf=%b", p, o, ep, eo);
      end
      // Called while done is high: start is presented during the done cycle.
      run_op(16'h8123, 16'h0456, -1, p, o, lat, bc);
      model(16'h8123, 16'h0456, ep, eo);
      checks++;
      if (p !== ep || o !== eo || lat != 16 || bc != 16) begin
         errors++;
         $display("FAIL b2b_second: product=%h ovf=%b lat=%0d busy=%0d, expected %h ovf=%b 16/16",
                  p, o, lat, bc, ep, eo);
      end
   endtask

   task automatic test_reset_abort();
      logic [15:0] p;
      logic        o;
      int          lat, bc;
      logic        saw_done;
      run_op(16'h0180, 16'h0200, -1, p, o, lat, bc);
      @(posedge clk); #1;
      start = 1'b1;
      multiplicand = 16'h7F00;
      multiplier = 16'h0200;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, ovf, product} !== 19'd0) begin
         errors++;
         $display("FAIL reset_abort: busy=%b done=%b ovf=%b product=%h, expected all 0",
                  busy, done, ovf, product);
      end
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done === 1'b1) saw_done = 1'b1;
      end
      checks++;
      if (saw_done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_done: saw_done=%b busy=%b, expected 0/0", saw_done, busy);
      end
      run_op(16'h7F00, 16'h0200, -1, p, o, lat, bc);
      checks++;
      if (p !== 16'h7FFF || o !== 1'b1 || lat != 16) begin
         errors++;
         $display("FAIL after_abort: product=%h ovf=%b lat=%0d, expected 7fff ovf=1 lat=16",
                  p, o, lat);
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_random();
      test_start_ignored();
      test_back_to_back();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
